// File: rtl/lq_ctrl_if.sv
// Load-queue controller bus: dispatch, entry status, retire and data-memory handshake.
// master is the controller side, slave is the surrounding pipeline / memory side.
interface lq_ctrl_if #(
    parameter int unsigned LQ_SIZE = 8,
    parameter int unsigned IDX_W   = $clog2(LQ_SIZE)
);
    logic               lq_flush;
    logic               disp_req1;
    logic               disp_req2;
    logic [LQ_SIZE-1:0] entry_addr_valid;
    logic [LQ_SIZE-1:0] entry_value_valid;
    logic               retire_head;
    logic               mem_req_ack;
    logic               mem_resp_valid;

    logic [LQ_SIZE-1:0] alloc_sel1;
    logic [LQ_SIZE-1:0] alloc_sel2;
    logic [IDX_W-1:0]   alloc_idx1;
    logic [IDX_W-1:0]   alloc_idx2;
    logic               lq_stall;
    logic [LQ_SIZE-1:0] free_sel;
    logic               clean_all;
    logic               mem_req_valid;
    logic [IDX_W-1:0]   mem_req_idx;
    logic [LQ_SIZE-1:0] resp_sel;
    logic               head_ready;
    logic [IDX_W:0]     lq_count;

    modport master (
        input  lq_flush, disp_req1, disp_req2, entry_addr_valid, entry_value_valid,
               retire_head, mem_req_ack, mem_resp_valid,
        output alloc_sel1, alloc_sel2, alloc_idx1, alloc_idx2, lq_stall, free_sel,
               clean_all, mem_req_valid, mem_req_idx, resp_sel, head_ready, lq_count
    );

    modport slave (
        output lq_flush, disp_req1, disp_req2, entry_addr_valid, entry_value_valid,
               retire_head, mem_req_ack, mem_resp_valid,
        input  alloc_sel1, alloc_sel2, alloc_idx1, alloc_idx2, lq_stall, free_sel,
               clean_all, mem_req_valid, mem_req_idx, resp_sel, head_ready, lq_count
    );
endinterface

// File: rtl/lq_ctrl.sv
// Load-queue controller: circular allocation (up to two per cycle), oldest-first issue to a
// single-port data memory with one request in flight, response steering, head retire, flush.
module lq_ctrl #(
    parameter int unsigned LQ_SIZE = 8,
    parameter int unsigned IDX_W   = $clog2(LQ_SIZE)
) (
    input  logic     clock,
    input  logic     reset,
    lq_ctrl_if.master bus
);
    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} mem_st_e;

    function automatic logic [LQ_SIZE-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    logic [IDX_W-1:0]   head_q, tail_q, req_idx_q;
    logic [IDX_W:0]     count_q;
    logic [LQ_SIZE-1:0] alloc_q, issued_q;
    mem_st_e            st_q;
    logic               mem_req_valid_q;

    logic [1:0]         needed;
    logic [IDX_W:0]     free_cnt;
    logic               cap_stall, do_alloc, do_retire, head_ready;
    logic [IDX_W-1:0]   idx1, idx2, pick_idx, scan_idx;
    logic [LQ_SIZE-1:0] sel1, sel2, free_sel, eligible, resp_sel;
    logic               found, issue_now;

    // Dispatch sizing, index assignment and head retire decode.
    always_comb begin
        needed    = {1'b0, bus.disp_req1} + {1'b0, bus.disp_req2};
        // Free space is taken before this cycle's retire, so a retire only helps next cycle.
        free_cnt  = (IDX_W+1)'(LQ_SIZE) - count_q;
        cap_stall = (IDX_W+1)'(needed) > free_cnt;
        do_alloc  = !bus.lq_flush && !cap_stall && (needed != 2'd0);
        idx1      = tail_q;
        // Slot 2 only takes tail when it is the sole load; otherwise it sits behind slot 1.
        idx2      = (bus.disp_req1 || !bus.disp_req2) ? tail_q + IDX_W'(1) : tail_q;
        sel1      = (do_alloc && bus.disp_req1) ? onehot(idx1) : '0;
        sel2      = (do_alloc && bus.disp_req2) ? onehot(idx2) : '0;
        head_ready = alloc_q[head_q] && bus.entry_value_valid[head_q];
        do_retire = bus.retire_head && head_ready && !bus.lq_flush;
        free_sel  = do_retire ? onehot(head_q) : '0;
    end

    // Oldest-first pick: scan a full circle starting at head; only live entries can match.
    always_comb begin
        eligible = alloc_q & bus.entry_addr_valid & ~issued_q & ~bus.entry_value_valid;
        found    = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < LQ_SIZE; i++) begin
            scan_idx = head_q + IDX_W'(i);
            if (!found && eligible[scan_idx]) begin
                found    = 1'b1;
                pick_idx = scan_idx;
            end
        end
        issue_now = (st_q == StIdle) && found && !bus.lq_flush;
        // Data steering must line up with the memory data beat, so it stays combinational.
        resp_sel  = (st_q == StWait && bus.mem_resp_valid && !bus.lq_flush) ?
                    onehot(req_idx_q) : '0;
    end

    // Queue pointers, occupancy and per-entry allocated/issued bits.
    always_ff @(posedge clock) begin
        if (reset || bus.lq_flush) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            alloc_q  <= '0;
            issued_q <= '0;
        end else begin
            if (do_alloc) tail_q <= tail_q + IDX_W'(needed);
            if (do_retire) head_q <= head_q + IDX_W'(1);
            count_q  <= count_q + (do_alloc ? (IDX_W+1)'(needed) : '0)
                        - (IDX_W+1)'(do_retire);
            alloc_q  <= (alloc_q | sel1 | sel2) & ~free_sel;
            issued_q <= (issued_q & ~(sel1 | sel2)) | (issue_now ? onehot(pick_idx) : '0);
        end
    end

    // Memory request FSM; DRAIN swallows the response of a request squashed in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            st_q            <= StIdle;
            req_idx_q       <= '0;
            mem_req_valid_q <= 1'b0;
        end else begin
            case (st_q)
                StIdle: begin
                    if (issue_now) begin
                        req_idx_q       <= pick_idx;
                        mem_req_valid_q <= 1'b1;
                        st_q            <= StReq;
                    end
                end
                StReq: begin
                    if (bus.lq_flush) begin
                        mem_req_valid_q <= 1'b0;
                        st_q            <= bus.mem_req_ack ? StDrain : StIdle;
                    end else if (bus.mem_req_ack) begin
                        mem_req_valid_q <= 1'b0;
                        st_q            <= StWait;
                    end
                end
                StWait: begin
                    if (bus.lq_flush) begin
                        st_q <= bus.mem_resp_valid ? StIdle : StDrain;
                    end else if (bus.mem_resp_valid) begin
                        st_q <= StIdle;
                    end
                end
                StDrain: begin
                    if (bus.mem_resp_valid) st_q <= StIdle;
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign bus.alloc_sel1    = sel1;
    assign bus.alloc_sel2    = sel2;
    assign bus.alloc_idx1    = idx1;
    assign bus.alloc_idx2    = idx2;
    assign bus.lq_stall      = bus.lq_flush || cap_stall;
    assign bus.free_sel      = free_sel;
    assign bus.clean_all     = bus.lq_flush;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_idx   = req_idx_q;
    assign bus.resp_sel      = resp_sel;
    assign bus.head_ready    = head_ready;
    assign bus.lq_count      = count_q;
endmodule

// File: tb/tb_lq_ctrl.sv
// Self-checking bench for lq_ctrl: a table of per-cycle vectors for dispatch/retire/flush,
// then hand-written sequences for the memory FSM, wrap-around and reset corners.
module tb_lq_ctrl;
    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    lq_ctrl_if bus ();

    lq_ctrl dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [7:0] sel1;
        logic [7:0] sel2;
        logic [2:0] idx1;
        logic [2:0] idx2;
        logic       stall;
        logic [7:0] free_sel;
        logic       clean;
        logic       mreq_v;
        logic [2:0] mreq_idx;
        logic [7:0] resp_sel;
        logic       head_ready;
        logic [3:0] count;
    } exp_t;

    typedef struct {
        logic       flush;
        logic       r1;
        logic       r2;
        logic [7:0] addr_v;
        logic [7:0] val_v;
        logic       retire;
        exp_t       exp;
    } vec_t;

    vec_t vecs[16];

    // Retiring a head that is not ready is illegal stimulus.
    always @(posedge clock) begin
        if (!reset && bus.retire_head && !bus.head_ready) begin
            $display("FAIL retire_guard: retire_head=1 with head_ready=%0b", bus.head_ready);
            n_fail++;
        end
    end

    task automatic set_vec(input int n, input logic fl, input logic r1, input logic r2,
                           input logic [7:0] av, input logic [7:0] vv, input logic ret,
                           input logic [7:0] s1, input logic [7:0] s2, input logic [2:0] i1,
                           input logic [2:0] i2, input logic st, input logic [7:0] fs,
                           input logic cl, input logic hr, input logic [3:0] cnt);
        vecs[n].flush  = fl;
        vecs[n].r1     = r1;
        vecs[n].r2     = r2;
        vecs[n].addr_v = av;
        vecs[n].val_v  = vv;
        vecs[n].retire = ret;
        vecs[n].exp    = '{s1, s2, i1, i2, st, fs, cl, 1'b0, 3'd0, 8'h00, hr, cnt};
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.lq_flush          = 1'b0;
        bus.disp_req1         = 1'b0;
        bus.disp_req2         = 1'b0;
        bus.entry_addr_valid  = '0;
        bus.entry_value_valid = '0;
        bus.retire_head       = 1'b0;
        bus.mem_req_ack       = 1'b0;
        bus.mem_resp_valid    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic next();
        @(negedge clock);
    endtask

    exp_t act;

    initial begin
        //       n  fl r1 r2 addr   val    ret sel1   sel2   i1 i2 st free   cl hr cnt
        set_vec(0,  0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);
        set_vec(1,  0, 1, 1, 8'h00, 8'h00, 0, 8'h01, 8'h02, 0, 1, 0, 8'h00, 0, 0, 0);
        set_vec(2,  0, 1, 1, 8'h00, 8'h00, 0, 8'h04, 8'h08, 2, 3, 0, 8'h00, 0, 0, 2);
        set_vec(3,  0, 1, 1, 8'h00, 8'h00, 0, 8'h10, 8'h20, 4, 5, 0, 8'h00, 0, 0, 4);
        set_vec(4,  0, 1, 1, 8'h00, 8'h00, 0, 8'h40, 8'h80, 6, 7, 0, 8'h00, 0, 0, 6);
        set_vec(5,  0, 1, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'h00, 0, 0, 8);
        set_vec(6,  0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'h00, 0, 0, 8);
        set_vec(7,  0, 0, 0, 8'h00, 8'h01, 1, 8'h00, 8'h00, 0, 1, 0, 8'h01, 0, 1, 8);
        set_vec(8,  0, 1, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'h00, 0, 0, 7);
        set_vec(9,  0, 0, 1, 8'h00, 8'h02, 1, 8'h00, 8'h01, 0, 0, 0, 8'h02, 0, 1, 7);
        set_vec(10, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 2, 0, 8'h00, 0, 0, 7);
        set_vec(11, 1, 1, 1, 8'h00, 8'h04, 1, 8'h00, 8'h00, 1, 2, 1, 8'h00, 1, 1, 7);
        set_vec(12, 0, 1, 0, 8'h00, 8'h00, 0, 8'h01, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);
        set_vec(13, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 2, 0, 8'h00, 0, 0, 1);
        set_vec(14, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h02, 1, 1, 0, 8'h00, 0, 0, 1);
        set_vec(15, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 2, 3, 0, 8'h00, 0, 0, 2);

        reset = 1'b1;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            next();
            bus.lq_flush          = vecs[i].flush;
            bus.disp_req1         = vecs[i].r1;
            bus.disp_req2         = vecs[i].r2;
            bus.entry_addr_valid  = vecs[i].addr_v;
            bus.entry_value_valid = vecs[i].val_v;
            bus.retire_head       = vecs[i].retire;
            #1;
            act = {bus.alloc_sel1, bus.alloc_sel2, bus.alloc_idx1, bus.alloc_idx2, bus.lq_stall,
                   bus.free_sel, bus.clean_all, bus.mem_req_valid, bus.mem_req_idx,
                   bus.resp_sel, bus.head_ready, bus.lq_count};
            n_tests++;
            if (act !== vecs[i].exp) begin
                n_fail++;
                $display("FAIL vec%0d: got %h expected %h", i, act, vecs[i].exp);
            end
        end

        // Oldest ready issues first, response steered to it, then the next one issues.
        do_reset();
        next(); bus.disp_req1 = 1'b1; bus.disp_req2 = 1'b1;
        next(); bus.disp_req2 = 1'b0;
        next(); bus.disp_req1 = 1'b0; bus.entry_addr_valid = 8'b0000_0110; #1;
        chk("A count3", bus.lq_count, 3);
        chk("A idle", bus.mem_req_valid, 0);
        next(); #1;
        chk("A req_v", bus.mem_req_valid, 1);
        chk("A req_idx1", bus.mem_req_idx, 1);
        next(); bus.mem_req_ack = 1'b1; #1;
        chk("A req_hold", {bus.mem_req_valid, bus.mem_req_idx}, {1'b1, 3'd1});
        next(); bus.mem_req_ack = 1'b0; bus.mem_resp_valid = 1'b1; #1;
        chk("A resp_sel", bus.resp_sel, 8'b0000_0010);
        chk("A wait_req_v", bus.mem_req_valid, 0);
        next(); bus.mem_resp_valid = 1'b0; bus.entry_value_valid = 8'b0000_0010; #1;
        chk("A resp_once", bus.resp_sel, 0);
        next(); #1;
        chk("A req_idx2", {bus.mem_req_valid, bus.mem_req_idx}, {1'b1, 3'd2});

        // Wrap-around allocation and oldest-first across the wrap; empty queue never issues.
        do_reset();
        repeat (3) begin
            next(); bus.disp_req1 = 1'b1; bus.disp_req2 = 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
            next(); bus.disp_req1 = 1'b0; bus.disp_req2 = 1'b0;
            bus.entry_value_valid = 8'hff; bus.retire_head = 1'b1; #1;
            chk("B free_sel", bus.free_sel, 32'(1) << k);
        end
        next(); bus.retire_head = 1'b0; bus.entry_value_valid = '0; bus.entry_addr_valid = 8'hff;
        #1;
        chk("B empty_count", bus.lq_count, 0);
        chk("B empty_head_ready", bus.head_ready, 0);
        next(); bus.entry_addr_valid = '0; bus.disp_req1 = 1'b1; bus.disp_req2 = 1'b1; #1;
        chk("B empty_no_issue", bus.mem_req_valid, 0);
        chk("B idx67", {bus.alloc_idx1, bus.alloc_idx2}, {3'd6, 3'd7});
        chk("B sel67", {bus.alloc_sel1, bus.alloc_sel2}, {8'h40, 8'h80});
        next(); #1;
        chk("B idx01", {bus.alloc_idx1, bus.alloc_idx2}, {3'd0, 3'd1});
        chk("B sel01", {bus.alloc_sel1, bus.alloc_sel2}, {8'h01, 8'h02});
        next(); bus.disp_req1 = 1'b0; bus.disp_req2 = 1'b0; bus.entry_addr_valid = 8'h41; #1;
        chk("B count4", bus.lq_count, 4);
        next(); #1;
        chk("B oldest6", {bus.mem_req_valid, bus.mem_req_idx}, {1'b1, 3'd6});

        // Flush while waiting for data: response is drained, not steered.
        do_reset();
        repeat (2) begin
            next(); bus.disp_req1 = 1'b1; bus.disp_req2 = 1'b1;
        end
        next(); bus.disp_req1 = 1'b0; bus.disp_req2 = 1'b0; bus.entry_addr_valid = 8'h08;
        next(); bus.mem_req_ack = 1'b1; #1;
        chk("C req_idx3", {bus.mem_req_valid, bus.mem_req_idx}, {1'b1, 3'd3});
        next(); bus.mem_req_ack = 1'b0; bus.lq_flush = 1'b1; #1;
        chk("C clean", bus.clean_all, 1);
        next(); bus.lq_flush = 1'b0; bus.disp_req1 = 1'b1; bus.entry_addr_valid = 8'h01; #1;
        chk("C clean_pulse", bus.clean_all, 0);
        chk("C count0", bus.lq_count, 0);
        chk("C alloc0", bus.alloc_sel1, 8'h01);
        next(); bus.disp_req1 = 1'b0; #1;
        chk("C no_req", bus.mem_req_valid, 0);
        next(); #1;
        chk("C drain_holds", bus.mem_req_valid, 0);
        next(); bus.mem_resp_valid = 1'b1; #1;
        chk("C drain_resp", bus.resp_sel, 0);
        next(); bus.mem_resp_valid = 1'b0; #1;
        chk("C back_idle", bus.mem_req_valid, 0);
        next(); #1;
        chk("C issue_after", {bus.mem_req_valid, bus.mem_req_idx}, {1'b1, 3'd0});

        // Reset while a request is pending; a late response is ignored.
        do_reset();
        next(); bus.disp_req1 = 1'b1;
        next(); bus.disp_req1 = 1'b0; bus.entry_addr_valid = 8'h02;
        bus.disp_req2 = 1'b1;
        next(); bus.disp_req2 = 1'b0; bus.entry_addr_valid = 8'h01;
        next(); #1;
        chk("D req_v", {bus.mem_req_valid, bus.mem_req_idx}, {1'b1, 3'd0});
        reset = 1'b1;
        next(); reset = 1'b0; bus.entry_addr_valid = '0; bus.mem_resp_valid = 1'b1; #1;
        chk("D req_cleared", bus.mem_req_valid, 0);
        chk("D count", bus.lq_count, 0);
        chk("D idx", {bus.alloc_idx1, bus.alloc_idx2, bus.mem_req_idx}, {3'd0, 3'd1, 3'd0});
        chk("D late_resp", bus.resp_sel, 0);
        chk("D head_ready", bus.head_ready, 0);
        next(); bus.mem_resp_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
